// File: rtl/dummy_xif_result_buffer.sv
// Commit-aware result buffer between the dummy coprocessor and the XIF result interface.
// Results are released strictly in order, and only once their ID has been committed; killed IDs are dropped.
module dummy_xif_result_buffer #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned XIF_ID_WIDTH = 4,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    commit_valid_i,
  input  logic [XIF_ID_WIDTH-1:0] commit_id_i,
  input  logic                    commit_kill_i,
  input  logic                    res_valid_i,
  output logic                    res_ready_o,
  input  logic [XIF_ID_WIDTH-1:0] res_id_i,
  input  logic [4:0]              res_rd_i,
  input  logic [DATA_WIDTH-1:0]   res_data_i,
  output logic                    result_valid_o,
  input  logic                    result_ready_i,
  output logic [XIF_ID_WIDTH-1:0] result_id_o,
  output logic [4:0]              result_rd_o,
  output logic [DATA_WIDTH-1:0]   result_data_o,
  output logic                    discard_o
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned NID = 1 << XIF_ID_WIDTH;

  typedef enum logic [1:0] {
    PENDING   = 2'd0,
    COMMITTED = 2'd1,
    KILLED    = 2'd2
  } commit_state_e;

  commit_state_e tbl_q [NID];
  commit_state_e tbl_d [NID];

  logic [PW-1:0]           wptr_q, rptr_q;
  logic [XIF_ID_WIDTH-1:0] id_mem   [DEPTH];
  logic [4:0]              rd_mem   [DEPTH];
  logic [DATA_WIDTH-1:0]   data_mem [DEPTH];

  logic                    full, empty, push, pop;
  logic [AW-1:0]           head_idx;
  logic [XIF_ID_WIDTH-1:0] head_id;
  commit_state_e           head_st;

  assign full     = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty    = (wptr_q == rptr_q);
  assign head_idx = rptr_q[AW-1:0];
  assign head_id  = id_mem[head_idx];
  assign head_st  = tbl_q[head_id];

  // Full is taken from registered pointers only, so a same-cycle pop never frees a slot early.
  assign res_ready_o = ~full;
  assign push        = res_valid_i & ~full;

  always_comb begin
    result_valid_o = 1'b0;
    discard_o      = 1'b0;
    result_id_o    = '0;
    result_rd_o    = '0;
    result_data_o  = '0;
    pop            = 1'b0;
    if (!empty) begin
      case (head_st)
        COMMITTED: begin
          result_valid_o = 1'b1;
          result_id_o    = head_id;
          result_rd_o    = rd_mem[head_idx];
          result_data_o  = data_mem[head_idx];
          pop            = result_ready_i;
        end
        KILLED: begin
          discard_o = 1'b1;
          pop       = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A commit overrides the pop-driven return to PENDING for the same ID in the same cycle.
  always_comb begin
    tbl_d = tbl_q;
    if (pop) tbl_d[head_id] = PENDING;
    if (commit_valid_i && ((tbl_q[commit_id_i] == PENDING) || (pop && (head_id == commit_id_i))))
      tbl_d[commit_id_i] = commit_kill_i ? KILLED : COMMITTED;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tbl_q  <= '{default: PENDING};
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      tbl_q <= tbl_d;
      if (push) wptr_q <= wptr_q + {{(PW-1){1'b0}}, 1'b1};
      if (pop)  rptr_q <= rptr_q + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      id_mem[wptr_q[AW-1:0]]   <= res_id_i;
      rd_mem[wptr_q[AW-1:0]]   <= res_rd_i;
      data_mem[wptr_q[AW-1:0]] <= res_data_i;
    end
  end

endmodule

// File: tb/tb_dummy_xif_result_buffer.sv
// Directed self-checking bench for dummy_xif_result_buffer (DEPTH=4, 4-bit IDs, 32-bit data).
module tb_dummy_xif_result_buffer;

  localparam int unsigned DW    = 32;
  localparam int unsigned IW    = 4;
  localparam int unsigned DEPTH = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          commit_valid_i, commit_kill_i;
  logic [IW-1:0] commit_id_i;
  logic          res_valid_i, res_ready_o;
  logic [IW-1:0] res_id_i;
  logic [4:0]    res_rd_i;
  logic [DW-1:0] res_data_i;
  logic          result_valid_o, result_ready_i;
  logic [IW-1:0] result_id_o;
  logic [4:0]    result_rd_o;
  logic [DW-1:0] result_data_o;
  logic          discard_o;

  int checks = 0;
  int errors = 0;

  dummy_xif_result_buffer #(
    .DATA_WIDTH  (DW),
    .XIF_ID_WIDTH(IW),
    .DEPTH       (DEPTH)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .commit_valid_i(commit_valid_i),
    .commit_id_i   (commit_id_i),
    .commit_kill_i (commit_kill_i),
    .res_valid_i   (res_valid_i),
    .res_ready_o   (res_ready_o),
    .res_id_i      (res_id_i),
    .res_rd_i      (res_rd_i),
    .res_data_i    (res_data_i),
    .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i),
    .result_id_o   (result_id_o),
    .result_rd_o   (result_rd_o),
    .result_data_o (result_data_o),
    .discard_o     (discard_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    commit_valid_i = 1'b0;
    commit_id_i    = '0;
    commit_kill_i  = 1'b0;
    res_valid_i    = 1'b0;
    res_id_i       = '0;
    res_rd_i       = '0;
    res_data_i     = '0;
    result_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_ni = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
    step();
  endtask

  task automatic drive_commit(input logic [IW-1:0] id, input logic kill);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
  endtask

  task automatic drive_push(input logic [IW-1:0] id, input logic [4:0] rd, input logic [DW-1:0] data);
    res_valid_i = 1'b1;
    res_id_i    = id;
    res_rd_i    = rd;
    res_data_i  = data;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", result_valid_o); end
    checks++; if (discard_o !== 1'b0) begin errors++; $display("FAIL reset_discard: got %b expected 0", discard_o); end
    checks++; if (res_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", res_ready_o); end
    checks++; if (result_data_o !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", result_data_o); end
    drive_commit(4'd7, 1'b0);
    step();
    commit_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_push(4'd7, 5'd1, 32'h70 + 32'(i));
      step();
    end
    res_valid_i = 1'b0;
    checks++; if (res_ready_o !== 1'b0) begin errors++; $display("FAIL prereset_full: got %b expected 0", res_ready_o); end
    checks++; if (result_valid_o !== 1'b1) begin errors++; $display("FAIL prereset_valid: got %b expected 1", result_valid_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b expected 0", result_valid_o); end
    checks++; if (discard_o !== 1'b0) begin errors++; $display("FAIL async_reset_discard: got %b expected 0", discard_o); end
    checks++; if (res_ready_o !== 1'b1) begin errors++; $display("FAIL async_reset_ready: got %b expected 1", res_ready_o); end
    step();
    rst_ni = 1'b1;
    step();
    step();
    checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL post_reset_empty: got %b expected 0", result_valid_o); end
    checks++; if (res_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", res_ready_o); end
  endtask

  task automatic test_commit_first();
    do_reset();
    result_ready_i = 1'b1;
    drive_commit(4'd3, 1'b0);
    step();
    commit_valid_i = 1'b0;
    drive_push(4'd3, 5'd5, 32'hCAFE_0001);
    step();
    res_valid_i = 1'b0;
    checks++; if (result_valid_o !== 1'b1) begin errors++; $display("FAIL cf_valid: got %b expected 1", result_valid_o); end
    checks++; if (result_rd_o !== 5'd5) begin errors++; $display("FAIL cf_rd: got %0d expected 5", result_rd_o); end
    checks++; if (result_data_o !== 32'hCAFE_0001) begin errors++; $display("FAIL cf_data: got %h expected cafe0001", result_data_o); end
    checks++; if (result_id_o !== 4'd3) begin errors++; $display("FAIL cf_id: got %0d expected 3", result_id_o); end
    step();
    checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL cf_popped: got %b expected 0", result_valid_o); end
    drive_push(4'd3, 5'd1, 32'h33);
    step();
    res_valid_i = 1'b0;
    checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL cf_entry_pending: got %b expected 0", result_valid_o); end
    step();
    checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL cf_entry_pending2: got %b expected 0", result_valid_o); end
  endtask

  task automatic test_result_first();
    do_reset();
    result_ready_i = 1'b1;
    drive_push(4'd2, 5'd7, 32'h22);
    step();
    res_valid_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL rf_wait_t%0d: got %b expected 0", k, result_valid_o); end
      if (k == 4) drive_commit(4'd2, 1'b0);
      step();
    end
    commit_valid_i = 1'b0;
    checks++; if (result_valid_o !== 1'b1) begin errors++; $display("FAIL rf_valid: got %b expected 1", result_valid_o); end
    checks++; if (result_data_o !== 32'h22) begin errors++; $display("FAIL rf_data: got %h expected 22", result_data_o); end
    step();
    checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL rf_drained: got %b expected 0", result_valid_o); end
  endtask

  task automatic test_kill();
    int            n_disc, n_out;
    logic [IW-1:0] got_id;
    logic [DW-1:0] got_data;
    n_disc = 0; n_out = 0; got_id = '0; got_data = '0;
    do_reset();
    result_ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      res_valid_i    = 1'b0;
      commit_valid_i = 1'b0;
      case (c)
        0: drive_push(4'd1, 5'd1, 32'h1);
        1: drive_push(4'd2, 5'd2, 32'h2);
        2: drive_commit(4'd1, 1'b1);
        3: drive_commit(4'd2, 1'b0);
        default: ;
      endcase
      if (discard_o) n_disc++;
      if (result_valid_o) begin
        n_out++;
        got_id   = result_id_o;
        got_data = result_data_o;
      end
      step();
    end
    clear_inputs();
    checks++; if (n_disc !== 1) begin errors++; $display("FAIL kill_discards: got %0d expected 1", n_disc); end
    checks++; if (n_out !== 1) begin errors++; $display("FAIL kill_outputs: got %0d expected 1", n_out); end
    checks++; if (got_id !== 4'd2) begin errors++; $display("FAIL kill_out_id: got %0d expected 2", got_id); end
    checks++; if (got_data !== 32'h2) begin errors++; $display("FAIL kill_out_data: got %h expected 2", got_data); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_commit(4'(i), 1'b0);
      step();
    end
    commit_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_push(4'(i), 5'(i), 32'hA0 + 32'(i));
      step();
    end
    checks++; if (res_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", res_ready_o); end
    drive_push(4'd4, 5'd4, 32'hDEAD);
    step();
    res_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (result_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid_%0d: got %b expected 1", k, result_valid_o); end
      checks++; if (result_data_o !== 32'hA0) begin errors++; $display("FAIL stall_data_%0d: got %h expected a0", k, result_data_o); end
      checks++; if (res_ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready_%0d: got %b expected 0", k, res_ready_o); end
      step();
    end
    result_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (result_valid_o !== 1'b1) begin errors++; $display("FAIL drain_valid_%0d: got %b expected 1", i, result_valid_o); end
      checks++; if (result_id_o !== 4'(i)) begin errors++; $display("FAIL drain_id_%0d: got %0d expected %0d", i, result_id_o, i); end
      checks++; if (result_data_o !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL drain_data_%0d: got %h expected %h", i, result_data_o, 32'hA0 + 32'(i)); end
      step();
    end
    checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b expected 0", result_valid_o); end
    checks++; if (res_ready_o !== 1'b1) begin errors++; $display("FAIL drain_ready: got %b expected 1", res_ready_o); end
  endtask

  task automatic test_wrap();
    int nexp, n_disc, first_c, last_c;
    nexp = 0; n_disc = 0; first_c = -1; last_c = -1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive_commit(4'(i), 1'b0);
      step();
    end
    commit_valid_i = 1'b0;
    result_ready_i = 1'b1;
    for (int c = 0; c < 16; c++) begin
      res_valid_i = 1'b0;
      if (c < 10) drive_push(4'(c % 16), 5'(c), 32'h1000 + 32'(c));
      if (discard_o) n_disc++;
      if (result_valid_o) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        checks++; if (result_id_o !== 4'(nexp % 16)) begin errors++; $display("FAIL wrap_id_%0d: got %0d expected %0d", nexp, result_id_o, nexp % 16); end
        checks++; if (result_data_o !== 32'h1000 + 32'(nexp)) begin errors++; $display("FAIL wrap_data_%0d: got %h expected %h", nexp, result_data_o, 32'h1000 + 32'(nexp)); end
        nexp++;
      end
      step();
    end
    clear_inputs();
    checks++; if (nexp !== 10) begin errors++; $display("FAIL wrap_count: got %0d expected 10", nexp); end
    checks++; if (n_disc !== 0) begin errors++; $display("FAIL wrap_discards: got %0d expected 0", n_disc); end
    checks++; if (first_c !== 1) begin errors++; $display("FAIL wrap_latency: got %0d expected 1", first_c); end
    checks++; if (last_c - first_c !== 9) begin errors++; $display("FAIL wrap_throughput: got %0d expected 9", last_c - first_c); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    drive_commit(4'd5, 1'b0);
    step();
    drive_commit(4'd5, 1'b1);
    step();
    commit_valid_i = 1'b0;
    drive_push(4'd5, 5'd9, 32'h55);
    step();
    res_valid_i = 1'b0;
    checks++; if (result_valid_o !== 1'b1) begin errors++; $display("FAIL first_commit_wins: got %b expected 1", result_valid_o); end
    checks++; if (discard_o !== 1'b0) begin errors++; $display("FAIL first_commit_discard: got %b expected 0", discard_o); end
    result_ready_i = 1'b1;
    step();
    result_ready_i = 1'b0;
    drive_commit(4'd6, 1'b0);
    step();
    commit_valid_i = 1'b0;
    drive_push(4'd6, 5'd6, 32'hA);
    step();
    checks++; if (result_valid_o !== 1'b1) begin errors++; $display("FAIL sc_valid: got %b expected 1", result_valid_o); end
    result_ready_i = 1'b1;
    drive_commit(4'd6, 1'b1);
    drive_push(4'd6, 5'd6, 32'hB);
    step();
    clear_inputs();
    checks++; if (discard_o !== 1'b1) begin errors++; $display("FAIL sc_commit_wins: got %b expected 1", discard_o); end
    checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL sc_killed_valid: got %b expected 0", result_valid_o); end
    step();
    checks++; if (discard_o !== 1'b0) begin errors++; $display("FAIL sc_discard_pulse: got %b expected 0", discard_o); end
    checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL sc_empty: got %b expected 0", result_valid_o); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_commit_first();
    test_result_first();
    test_kill();
    test_full();
    test_wrap();
    test_same_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
